// File: rtl/pipe_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Default widths, debug register index and register typedefs
//               shared by the pipelined register file and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int C_ADDRESS_WIDTH = 5;
    localparam int C_DATA_WIDTH    = 32;
    localparam int C_NUM_READ      = 2;
    localparam int C_DEBUG_REG     = 10;

    typedef logic [C_ADDRESS_WIDTH-1:0] reg_idx_t;
    typedef logic [C_DATA_WIDTH-1:0]    reg_word_t;

endpackage
`default_nettype wire

// File: rtl/pipe_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_regfile_if
// Description : Write, read, issue and debug signals of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_regfile_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2
);
    logic                           we;
    logic [ADDRESS_WIDTH-1:0]       wa;
    logic [DATA_WIDTH-1:0]          wd;
    logic [NUM_READ*ADDRESS_WIDTH-1:0] ra;
    logic [NUM_READ*DATA_WIDTH-1:0] rd;
    logic [NUM_READ-1:0]            rbusy;
    logic                           iss_valid;
    logic [ADDRESS_WIDTH-1:0]       iss_rd;
    logic                           iss_ready;
    logic [ADDRESS_WIDTH:0]         busy_cnt;
    logic [DATA_WIDTH-1:0]          a0;

    modport master (
        output we, wa, wd, ra, iss_valid, iss_rd,
        input  rd, rbusy, iss_ready, busy_cnt, a0
    );

    modport slave (
        input  we, wa, wd, ra, iss_valid, iss_rd,
        output rd, rbusy, iss_ready, busy_cnt, a0
    );
endinterface
`default_nettype wire

// File: rtl/pipe_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits with WAW issue stall and busy count.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = C_ADDRESS_WIDTH,
    parameter int NUM_READ      = C_NUM_READ
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              i_we,
    input  wire logic [ADDRESS_WIDTH-1:0]          i_wa,
    input  wire logic                              i_iss_valid,
    input  wire logic [ADDRESS_WIDTH-1:0]          i_iss_rd,
    input  wire logic [NUM_READ*ADDRESS_WIDTH-1:0] i_ra,
    output logic      [NUM_READ-1:0]               o_rbusy,
    output logic                                   o_iss_ready,
    output logic      [ADDRESS_WIDTH:0]            o_busy_cnt
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DEPTH-1:0]       r_busy_q, w_busy_d;
    logic [ADDRESS_WIDTH:0] r_cnt_q, w_cnt_d;
    logic                   w_clr, w_clr_iss, w_ready, w_set, w_inc, w_dec;

    always_comb begin
        w_clr     = i_we && (i_wa != '0);
        w_clr_iss = w_clr && (i_wa == i_iss_rd);
        // A busy destination may still issue if this cycle's write retires it
        w_ready   = !((i_iss_rd != '0) && r_busy_q[i_iss_rd] && !w_clr_iss);
        w_set     = i_iss_valid && w_ready && (i_iss_rd != '0);
        w_inc     = w_set && !r_busy_q[i_iss_rd];
        w_dec     = w_clr && r_busy_q[i_wa] && !(w_set && (i_iss_rd == i_wa));

        w_busy_d = r_busy_q;
        if (w_clr) w_busy_d[i_wa] = 1'b0;
        if (w_set) w_busy_d[i_iss_rd] = 1'b1;

        w_cnt_d = r_cnt_q + {{ADDRESS_WIDTH{1'b0}}, w_inc}
                          - {{ADDRESS_WIDTH{1'b0}}, w_dec};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_busy_q <= w_busy_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    always_comb begin
        o_rbusy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            o_rbusy[i] = r_busy_q[i_ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
        end
    end

    assign o_iss_ready = w_ready;
    assign o_busy_cnt  = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pipe_regfile
// Description : Multi-read register file with issue scoreboard and debug tap.
//               Define PIPE_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_regfile
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = C_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = C_DATA_WIDTH,
    parameter int NUM_READ      = C_NUM_READ,
    parameter int DEBUG_REG     = C_DEBUG_REG
) (
    input wire logic clk,
    input wire logic rst,
    pipe_regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] C_DEBUG_IDX = ADDRESS_WIDTH'(DEBUG_REG);

    logic [DATA_WIDTH-1:0]          r_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]          w_mem_d [DEPTH];
    logic                           w_wr_en;
    logic [NUM_READ-1:0]            w_sb_rbusy;
    logic                           w_sb_ready;
    logic [ADDRESS_WIDTH:0]         w_sb_cnt;
    logic [ADDRESS_WIDTH-1:0]       w_ra;
    logic [NUM_READ*DATA_WIDTH-1:0] w_rd_all;
    logic [NUM_READ-1:0]            w_rbusy_all;
    logic [DATA_WIDTH-1:0]          w_a0;

    assign w_wr_en = bus.we && (bus.wa != '0);

    // Entry 0 is never written, so it holds its reset value of zero
    always_comb begin
        w_mem_d = r_mem_q;
        if (w_wr_en) w_mem_d[bus.wa] = bus.wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) r_mem_q[j] <= '0;
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_READ      (NUM_READ)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_we        (bus.we),
        .i_wa        (bus.wa),
        .i_iss_valid (bus.iss_valid),
        .i_iss_rd    (bus.iss_rd),
        .i_ra        (bus.ra),
        .o_rbusy     (w_sb_rbusy),
        .o_iss_ready (w_sb_ready),
        .o_busy_cnt  (w_sb_cnt)
    );

    always_comb begin
        w_rd_all    = '0;
        w_rbusy_all = '0;
        w_ra        = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            w_ra = bus.ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            if (w_ra != '0) w_rd_all[i*DATA_WIDTH +: DATA_WIDTH] = r_mem_q[w_ra];
            w_rbusy_all[i] = w_sb_rbusy[i];
`ifdef PIPE_REGFILE_BYPASS_EN
            // Forwarded data is no longer pending unless re-issued this cycle
            if (w_wr_en && (w_ra == bus.wa)) begin
                w_rd_all[i*DATA_WIDTH +: DATA_WIDTH] = bus.wd;
                w_rbusy_all[i] = bus.iss_valid && w_sb_ready && (bus.iss_rd == bus.wa);
            end
`endif
        end
        if (rst) begin
            w_rd_all    = '0;
            w_rbusy_all = '0;
        end
    end

    always_comb begin
        w_a0 = (C_DEBUG_IDX != '0) ? r_mem_q[C_DEBUG_IDX] : '0;
`ifdef PIPE_REGFILE_BYPASS_EN
        if (w_wr_en && (bus.wa == C_DEBUG_IDX)) w_a0 = bus.wd;
`endif
        if (rst) w_a0 = '0;
    end

    assign bus.rd        = w_rd_all;
    assign bus.rbusy     = w_rbusy_all;
    assign bus.iss_ready = w_sb_ready | rst;
    assign bus.busy_cnt  = w_sb_cnt;
    assign bus.a0        = w_a0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_regfile
// Description : Directed and randomized self-checking bench for pipe_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_regfile;
    import regfile_pkg::*;

    localparam int AW    = C_ADDRESS_WIDTH;
    localparam int DW    = C_DATA_WIDTH;
    localparam int NR    = C_NUM_READ;
    localparam int DEPTH = 1 << AW;
    localparam int DBG   = C_DEBUG_REG;
`ifdef PIPE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_regfile_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus ();

    pipe_regfile #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_READ      (NR),
        .DEBUG_REG     (DBG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reg_word_t m_mem  [DEPTH];
    bit        m_busy [DEPTH];
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_wr();
        return (bus.we === 1'b1) && (bus.wa != '0);
    endfunction

    function automatic bit m_ready();
        return !((bus.iss_rd != '0) && m_busy[bus.iss_rd] && !(m_wr() && bus.wa == bus.iss_rd));
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (rst || a == '0) return '0;
        if (BYP && m_wr() && a == bus.wa) return bus.wd;
        return m_mem[a];
    endfunction

    function automatic bit m_rbusy(input logic [AW-1:0] a);
        if (rst || a == '0) return 1'b0;
        if (BYP && m_wr() && a == bus.wa) return bus.iss_valid && m_ready() && bus.iss_rd == a;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int k = 0; k < DEPTH; k++) n += int'(m_busy[k]);
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    task automatic model_commit();
        bit acc;
        logic [AW-1:0] ird;
        if (rst) return;
        acc = bus.iss_valid && m_ready();
        ird = bus.iss_rd;
        if (m_wr()) begin
            m_mem[bus.wa]  = bus.wd;
            m_busy[bus.wa] = 1'b0;
        end
        if (acc && ird != '0) m_busy[ird] = 1'b1;
    endtask

    task automatic compare_all();
        logic [AW-1:0] a;
        for (int i = 0; i < NR; i++) begin
            a = bus.ra[i*AW +: AW];
            chk($sformatf("rd%0d[x%0d]", i, a), bus.rd[i*DW +: DW], m_read(a));
            chk($sformatf("rbusy%0d[x%0d]", i, a), bus.rbusy[i], m_rbusy(a));
        end
        chk("iss_ready", bus.iss_ready, rst ? 1'b1 : m_ready());
        chk("busy_cnt", bus.busy_cnt, m_count());
        chk("a0", bus.a0, m_read(AW'(DBG)));
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input bit iv, input logic [AW-1:0] ird);
        bus.we = we;
        bus.wa = wa;
        bus.wd = wd;
        for (int i = 0; i < NR; i++) bus.ra[i*AW +: AW] = (i == 1) ? ra1 : ra0;
        bus.iss_valid = iv;
        bus.iss_rd    = ird;
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        drive(1'b0, '0, '0, ra0, ra1, 1'b0, '0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        idle('0, '0);
        model_reset();

        // Reset state while rst is held
        @(negedge clk);
        compare_all();
        chk("reset_ready", bus.iss_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Every register reads zero after reset
        for (int r = 0; r < DEPTH; r += 2) begin
            idle(AW'(r), AW'(r + 1));
            cycle();
        end
        chk("reset_cnt", bus.busy_cnt, 0);

        // x0 is hard-wired; x10 mirrors onto a0
        drive(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, '0);
        cycle();
        idle(5'd0, 5'd0);
        #1 chk("x0_read", bus.rd[DW-1:0], 32'h0);
        drive(1'b1, 5'd10, 32'h12345678, 5'd10, 5'd0, 1'b0, '0);
        cycle();
        idle(5'd10, 5'd0);
        #1 chk("a0_x10", bus.a0, 32'h12345678);

        // WAW stall on x5, then retire it
        drive(1'b0, '0, '0, 5'd5, 5'd0, 1'b1, 5'd5);
        cycle();
        drive(1'b0, '0, '0, 5'd5, 5'd0, 1'b1, 5'd5);
        #1 chk("waw_ready", bus.iss_ready, 1'b0);
        chk("waw_cnt", bus.busy_cnt, 1);
        cycle();
        drive(1'b1, 5'd5, 32'hA5, 5'd5, 5'd0, 1'b0, '0);
        cycle();
        idle(5'd5, 5'd0);
        #1 chk("x5_cnt", bus.busy_cnt, 0);
        chk("x5_rd", bus.rd[DW-1:0], 32'hA5);
        chk("x5_rbusy", bus.rbusy[0], 1'b0);

        // Write and re-issue x7 together: set wins
        drive(1'b0, '0, '0, 5'd7, 5'd0, 1'b1, 5'd7);
        cycle();
        drive(1'b1, 5'd7, 32'h77, 5'd7, 5'd0, 1'b1, 5'd7);
        cycle();
        idle(5'd7, 5'd0);
        #1 chk("x7_rbusy", bus.rbusy[0], 1'b1);
        chk("x7_cnt", bus.busy_cnt, 1);
        chk("x7_rd", bus.rd[DW-1:0], 32'h77);
        drive(1'b1, 5'd7, 32'h77, 5'd7, 5'd0, 1'b0, '0);
        cycle();

        // Same-cycle read of a register being written
        drive(1'b1, 5'd3, 32'h33, 5'd3, 5'd0, 1'b0, '0);
        #1 chk("byp_rd", bus.rd[DW-1:0], BYP ? 32'h33 : 32'h0);
        chk("byp_rbusy", bus.rbusy[0], 1'b0);
        cycle();
        idle(5'd3, 5'd0);
        #1 chk("x3_next", bus.rd[DW-1:0], 32'h33);

        // Asynchronous reset between clock edges
        drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b1, 5'd1); cycle();
        drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b1, 5'd2); cycle();
        drive(1'b0, '0, '0, 5'd0, 5'd0, 1'b1, 5'd3); cycle();
        drive(1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b0, '0); cycle();
        idle(5'd4, 5'd1);
        #1 chk("pre_rst_cnt", bus.busy_cnt, 3);
        chk("pre_rst_rd", bus.rd[DW-1:0], 32'h44);
        rst = 1'b1;
        model_reset();
        #1 chk("async_cnt", bus.busy_cnt, 0);
        chk("async_rd", bus.rd[DW-1:0], 32'h0);
        chk("async_ready", bus.iss_ready, 1'b1);
        rst = 1'b0;
        #1 chk("post_rst_rd", bus.rd[DW-1:0], 32'h0);
        chk("post_rst_rbusy", bus.rbusy[1], 1'b0);
        chk("post_rst_cnt", bus.busy_cnt, 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom, rnd_addr(), rnd_addr(),
                  1'($urandom_range(0, 1)), rnd_addr());
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5: register index width; depth is 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width, bits [DATA_WIDTH-1:0].
REQ-003 SHALL have parameter NUM_READ, default 2, legal range 1..4: number of independent read ports.
REQ-004 SHALL have parameter DEBUG_REG, default 10: index of the register mirrored on the a0 port.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, as the two ports below.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 we  input  1  write enable.
REQ-009 wa  input  ADDRESS_WIDTH  write address.
REQ-010 wd  input  DATA_WIDTH  write data.
REQ-011 ra  input  NUM_READ x ADDRESS_WIDTH  read addresses, packed; port i at slice i.
REQ-012 rd  output  NUM_READ x DATA_WIDTH  read data, packed.
REQ-013 rbusy  output  NUM_READ  scoreboard busy bit for each ra[i].
REQ-014 iss_valid  input  1  issue request marking a destination register pending.
REQ-015 iss_rd  input  ADDRESS_WIDTH  destination register of the issue request.
REQ-016 iss_ready  output  1  issue is accepted this cycle.
REQ-017 busy_cnt  output  ADDRESS_WIDTH+1  number of registers currently busy.
REQ-018 a0  output  DATA_WIDTH  current committed value of register DEBUG_REG.

Function
REQ-019 Register 0 SHALL read as 0 on all ports, SHALL never be written, and SHALL never be marked busy.
REQ-020 A write SHALL commit on the rising clk edge when we=1 and wa!=0.
REQ-021 Reads SHALL be combinational from the committed register array: zero-cycle latency, no handshake.
REQ-022 iss_ready SHALL be 0 when iss_rd!=0, iss_rd is busy, and no same-cycle write to iss_rd is clearing it; otherwise iss_ready SHALL be 1. This stalls WAW hazards.
REQ-023 An issue is accepted when iss_valid & iss_ready; it SHALL set busy[iss_rd] at the clock edge, except for iss_rd=0.
REQ-024 A committed write to wa SHALL clear busy[wa] at the clock edge.
REQ-025 A write to a register that is not busy SHALL still commit its data; busy_cnt SHALL be unchanged.
REQ-026 When a write and an accepted issue target the same register in one cycle, the data SHALL commit and busy SHALL remain 1 (set wins).
REQ-027 rbusy[i] SHALL equal busy[ra[i]] before any same-cycle update; rbusy[i]=0 when ra[i]=0.
REQ-028 busy_cnt SHALL equal the population count of busy[] at all times: +1 per new set, -1 per clear, net 0 on a simultaneous set and clear.
REQ-029 a0 SHALL show register DEBUG_REG, bypassed under the same rule as the read ports.

Reset
REQ-030 Asserting rst SHALL immediately, independent of clk, clear all registers to 0, all busy bits to 0, and busy_cnt to 0.
REQ-031 While rst is high, rd, a0 and rbusy SHALL read 0 and iss_ready SHALL be 1.
REQ-032 An operation in flight when rst asserts SHALL be discarded, with no partial commit after release.

Configuration
REQ-033 When macro PIPE_REGFILE_BYPASS_EN is defined: if we=1, wa!=0 and ra[i]==wa, rd[i] SHALL return wd in the same cycle and rbusy[i] SHALL be 0 unless an accepted issue to the same register occurs that cycle.
REQ-034 When PIPE_REGFILE_BYPASS_EN is not defined: rd[i] and rbusy[i] SHALL reflect committed state only, and new data SHALL be visible the cycle after the write.

Structure
REQ-035 Package regfile_pkg SHALL hold the default width constants, the DEBUG_REG default, and typedefs for the register index and data word.
REQ-036 The busy vector and busy_cnt SHALL be implemented in sub-module regfile_scoreboard; the data array and bypass logic SHALL live in pipe_regfile.

Verification
REQ-037 Reset, then read all 32 registers -> all rd = 0, busy_cnt = 0, iss_ready = 1.
REQ-038 Write 0xDEADBEEF to x0, then read x0 -> 0; write 0x12345678 to x10 -> a0 = 0x12345678 next cycle.
REQ-039 Issue x5, then issue x5 again -> iss_ready = 0 and busy_cnt = 1; write x5 = 0xA5 -> busy clears, busy_cnt = 0, rd = 0xA5.
REQ-040 Same cycle: write x7 = 0x77 and issue x7 -> busy[7] = 1, busy_cnt unchanged at 1, rd(x7) = 0x77.
REQ-041 With BYPASS_EN, write x3 = 0x33 and read x3 in the same cycle -> rd = 0x33, rbusy = 0; without BYPASS_EN -> old value that cycle, 0x33 next cycle.
REQ-042 Set busy on x1, x2 and x3, then pulse rst mid-cycle -> busy_cnt = 0 and all data = 0 immediately, with no clock edge.
